if_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the control unit (CU).
//  - Owns the PC and issues one word fetch at a time to instruction memory over a req/rsp handshake.
//  - Holds the fetched word with its PC and presents opcode/func3/func7 slices to CU.
//  - Accepts branch/jump redirects and squashes wrong-path fetches.

---
 rtl/rv_pkg.sv | 36 +++
 rtl/if_id_reg.sv | 46 ++++
 rtl/if_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Definitions shared by the fetch stage and the control unit:
//   XLEN          datapath / PC width
//   NOP_INSTR     canonical nop (addi x0, x0, 0) used as the empty IF/ID value
//   opcode_t      major opcodes decoded by the CU
//   fetch_state_t fetch FSM states, also exported on the debug port
// ---------------------------------------------------------------------------
package rv_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'h03,
      OPC_OP_IMM = 7'h13,
      OPC_AUIPC  = 7'h17,
      OPC_STORE  = 7'h23,
      OPC_OP     = 7'h33,
      OPC_LUI    = 7'h37,
      OPC_BRANCH = 7'h63,
      OPC_JALR   = 7'h67,
      OPC_JAL    = 7'h6F,
      OPC_SYSTEM = 7'h73
   } opcode_t;

   // REQ   : request may be issued to imem
   // WAIT  : one request outstanding, its response will be captured
   // DRAIN : one request outstanding, its response is wrong-path and dropped
   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register holding one fetched instruction and its PC.
// Priority: reset > flush > capture > consume.
//   clk, rst_n   clock, synchronous active-low reset
//   flush        drop the held instruction (redirect)
//   capture      load instr_in/pc_in and mark valid
//   consume      decode took the instruction this cycle
//   instr_in     fetched word
//   pc_in        PC of the fetched word
//   valid        register holds a valid instruction
//   instr, pc    held instruction and its PC
// ---------------------------------------------------------------------------
module if_id_reg #(
   parameter int XLEN = rv_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            capture,
   input  logic            consume,
   input  logic [31:0]     instr_in,
   input  logic [XLEN-1:0] pc_in,
   output logic            valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc
);
   import rv_pkg::*;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
         pc    <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (capture) begin
         valid <= 1'b1;
         instr <= instr_in;
         pc    <= pc_in;
      end else if (consume) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction fetch stage with IF/ID register, feeding the control unit.
// Owns the PC, keeps at most one imem request outstanding, and squashes
// wrong-path responses after a branch/jump redirect.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high (imem_req_valid/imem_req_ready, id_valid/id_ready); a valid
// source holds its payload until the transfer. imem_rsp_valid has no
// back-pressure and is only honoured while a request is outstanding.
//
//   clk, rst_n       clock, synchronous active-low reset
//   imem_req_*       fetch request (valid/ready), imem_addr = pc
//   imem_rsp_*       returned instruction word
//   redirect(_pc)    taken branch/jump from EX, one-cycle pulse
//   id_ready         decode consumes id_* this cycle
//   id_valid/instr/pc  IF/ID register contents
//   id_opcode/func3/func7  field slices of id_instr for the CU
//   misalign_err     sticky: a redirect target was not word aligned
//   fetch_state      debug view of the fetch FSM state
// ---------------------------------------------------------------------------
module if_stage #(
   parameter int              XLEN     = rv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 imem_req_valid,
   input  logic                 imem_req_ready,
   output logic [XLEN-1:0]      imem_addr,
   input  logic                 imem_rsp_valid,
   input  logic [31:0]          imem_rsp_data,
   input  logic                 redirect,
   input  logic [XLEN-1:0]      redirect_pc,
   input  logic                 id_ready,
   output logic                 id_valid,
   output logic [31:0]          id_instr,
   output logic [XLEN-1:0]      id_pc,
   output logic [6:0]           id_opcode,
   output logic [2:0]           id_func3,
   output logic [6:0]           id_func7,
   output logic                 misalign_err,
   output rv_pkg::fetch_state_t fetch_state
);
   import rv_pkg::*;

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic            capture;
   logic            consume;

   // A response is only kept when it answers a right-path request and no
   // redirect lands on the same edge.
   assign capture = (state == WAIT) && imem_rsp_valid && !redirect;
   assign consume = id_valid && id_ready;

   // Requesting only when the IF/ID slot is empty or draining this cycle
   // guarantees room for the response, since a request is never outstanding
   // while the slot is full.
   assign imem_req_valid = rst_n && (state == REQ) && (!id_valid || id_ready) && !redirect;
   assign imem_addr      = pc;
   assign fetch_state    = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= REQ;
         pc           <= RESET_PC;
         misalign_err <= 1'b0;
      end else if (redirect) begin
         pc           <= {redirect_pc[XLEN-1:2], 2'b00};
         misalign_err <= misalign_err | (redirect_pc[1:0] != 2'b00);
         // An outstanding request whose response has not arrived yet must
         // be drained so its word never reaches IF/ID.
         if ((state == WAIT || state == DRAIN) && !imem_rsp_valid) begin
            state <= DRAIN;
         end else begin
            state <= REQ;
         end
      end else begin
         case (state)
            REQ: begin
               if (imem_req_valid && imem_req_ready) state <= WAIT;
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  pc    <= pc + XLEN'(4);
                  state <= REQ;
               end
            end
            DRAIN: begin
               if (imem_rsp_valid) state <= REQ;
            end
            default: state <= REQ;
         endcase
      end
   end

   if_id_reg #(.XLEN(XLEN)) u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect),
      .capture  (capture),
      .consume  (consume),
      .instr_in (imem_rsp_data),
      .pc_in    (pc),
      .valid    (id_valid),
      .instr    (id_instr),
      .pc       (id_pc)
   );

   assign id_opcode = id_instr[6:0];
   assign id_func3  = id_instr[14:12];
   assign id_func7  = id_instr[31:25];

endmodule
